// File: rtl/alu_sequencer.sv
// Issue-side controller for the combinational alu: valid/ready request intake, held response,
// and unsigned 16x16->32 shift-add multiply on ALU_ADD. ALU_SEQ_B2B_EN enables retire+accept in DONE.
`ifndef ALU_ADD
`define ALU_ADD        3'd0
`define ALU_SUBTRACT   3'd1
`define ALU_AND        3'd2
`define ALU_OR         3'd3
`define ALU_COMPLEMENT 3'd4
`endif
`ifndef OVERFLOWFLAG
`define OVERFLOWFLAG 3
`define ZEROFLAG     2
`define CARRYFLAG    1
`define NEGFLAG      0
`endif

module alu_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mul,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_result_hi,
  output logic [3:0]       rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic             accept;

  function automatic logic [3:0] mul_flags(input logic [2*WIDTH-1:0] p);
    logic [3:0] f;
    f                = 4'd0;
    f[`ZEROFLAG]     = (p == '0);
    f[`NEGFLAG]      = p[2*WIDTH-1];
    f[`CARRYFLAG]    = (p[2*WIDTH-1:WIDTH] != '0);
    f[`OVERFLOWFLAG] = 1'b0;
    return f;
  endfunction

`ifdef ALU_SEQ_B2B_EN
  assign req_ready = ((state == IDLE) | ((state == DONE) & rsp_ready)) & ~reset;
`else
  assign req_ready = (state == IDLE) & ~reset;
`endif
  assign accept = req_valid & req_ready;

  // One shift-add step: the alu carry becomes the new top bit of the 32-bit accumulator.
  always_comb begin
    nxt_hi = {alu_flags[`CARRYFLAG], alu_result[WIDTH-1:1]};
    nxt_lo = {alu_result[0], acc_lo[WIDTH-1:1]};
  end

  // Sequencer state, alu drive registers and held response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mcand         <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      cnt           <= 5'd0;
      alu_op        <= 3'd0;
      alu_a         <= '0;
      alu_b         <= '0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_result_hi <= '0;
      rsp_flags     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          alu_op <= 3'd0;
          alu_a  <= '0;
          alu_b  <= '0;
        end
        EXEC: begin
          rsp_result    <= alu_result;
          rsp_result_hi <= '0;
          rsp_flags     <= alu_flags;
          rsp_valid     <= 1'b1;
          alu_op        <= 3'd0;
          alu_a         <= '0;
          alu_b         <= '0;
          state         <= DONE;
        end
        MUL: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MUL_STEPS - 1)) begin
            rsp_result    <= nxt_lo;
            rsp_result_hi <= nxt_hi;
            rsp_flags     <= mul_flags({nxt_hi, nxt_lo});
            rsp_valid     <= 1'b1;
            alu_op        <= 3'd0;
            alu_a         <= '0;
            alu_b         <= '0;
            state         <= DONE;
          end else begin
            alu_op <= `ALU_ADD;
            alu_a  <= nxt_hi;
            alu_b  <= acc_lo[1] ? mcand : '0;
          end
        end
        DONE: begin
          alu_op <= 3'd0;
          alu_a  <= '0;
          alu_b  <= '0;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase

      // A new request overrides the retire-to-IDLE above when back-to-back issue is enabled.
      if (accept) begin
        if (req_mul) begin
          state  <= MUL;
          mcand  <= req_a;
          acc_hi <= '0;
          acc_lo <= req_b;
          cnt    <= 5'd0;
          alu_op <= `ALU_ADD;
          alu_a  <= '0;
          alu_b  <= req_b[0] ? req_a : '0;
        end else begin
          state  <= EXEC;
          alu_op <= req_op;
          alu_a  <= req_a;
          alu_b  <= req_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural alu model; honours ALU_SEQ_B2B_EN.
`timescale 1ns/1ps
`ifndef ALU_ADD
`define ALU_ADD        3'd0
`define ALU_SUBTRACT   3'd1
`define ALU_AND        3'd2
`define ALU_OR         3'd3
`define ALU_COMPLEMENT 3'd4
`endif
`ifndef OVERFLOWFLAG
`define OVERFLOWFLAG 3
`define ZEROFLAG     2
`define CARRYFLAG    1
`define NEGFLAG      0
`endif

module tb_alu_sequencer;

  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mul = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result, rsp_result_hi;
  logic [3:0]  rsp_flags;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   rsp_cycles[$];

  alu_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mul(req_mul), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_result_hi(rsp_result_hi), .rsp_flags(rsp_flags)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t ref_simple(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    logic v;
    s = 17'd0;
    v = 1'b0;
    case (op)
      `ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[15] == b[15]) && (s[15] != a[15]);
      end
      `ALU_SUBTRACT: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        v = (a[15] != b[15]) && (s[15] != a[15]);
      end
      `ALU_AND:        s = {1'b0, a & b};
      `ALU_OR:         s = {1'b0, a | b};
      `ALU_COMPLEMENT: s = {1'b0, ~a};
      default:         s = 17'd0;
    endcase
    e.lo = s[15:0];
    e.hi = 16'd0;
    e.fl = 4'd0;
    e.fl[`OVERFLOWFLAG] = v;
    e.fl[`ZEROFLAG]     = (s[15:0] == 16'd0);
    e.fl[`CARRYFLAG]    = s[16];
    e.fl[`NEGFLAG]      = s[15];
    return e;
  endfunction

  function automatic exp_t ref_mul(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    e.lo = p[15:0];
    e.hi = p[31:16];
    e.fl = 4'd0;
    e.fl[`ZEROFLAG]  = (p == 32'd0);
    e.fl[`NEGFLAG]   = p[31];
    e.fl[`CARRYFLAG] = (p[31:16] != 16'd0);
    return e;
  endfunction

  // Behavioural combinational alu sitting behind the sequencer.
  always_comb begin
    exp_t r;
    r = ref_simple(alu_op, alu_a, alu_b);
    alu_result = r.lo;
    alu_flags  = r.fl;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Retired responses are compared against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", {16'd0, rsp_result}, {16'd0, e.lo});
        check("rsp_result_hi", {16'd0, rsp_result_hi}, {16'd0, e.hi});
        check("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.fl});
      end
      rsp_cycles.push_back(cyc);
    end
  end

  task automatic issue(input logic mul, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(negedge clock);
    req_valid = 1'b1; req_mul = mul; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(mul ? ref_mul(a, b) : ref_simple(op, a, b));
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    #1;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_alu", {13'd0, alu_op, alu_a}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    issue(1'b0, `ALU_ADD, 16'h7FFF, 16'h0001);
    wait_rsp(lat);
    check("add_latency", lat, 32'd1);
    check("add_result", {16'd0, rsp_result}, 32'h8000);
    check("add_flags", {28'd0, rsp_flags}, 32'b1001);
    repeat (3) @(negedge clock);

    issue(1'b1, 3'd5, 16'hFFFF, 16'hFFFF);
    wait_rsp(lat);
    check("mul_latency", lat, 32'd16);
    check("mul_product", {rsp_result_hi, rsp_result}, 32'hFFFE0001);
    check("mul_flags", {28'd0, rsp_flags}, 32'b0011);
    repeat (3) @(negedge clock);

    issue(1'b1, `ALU_OR, 16'h0000, 16'h1234);
    wait_rsp(lat);
    check("mul0_product", {rsp_result_hi, rsp_result}, 32'd0);
    check("mul0_flags", {28'd0, rsp_flags}, 32'b0100);
    repeat (3) @(negedge clock);

    rsp_ready = 1'b0;
    issue(1'b0, `ALU_SUBTRACT, 16'd5, 16'd3);
    wait_rsp(lat);
    req_valid = 1'b1; req_mul = 1'b0; req_op = `ALU_OR; req_a = 16'h00F0; req_b = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_result", {16'd0, rsp_result}, 32'h0002);
      check("hold_flags", {28'd0, rsp_flags}, 32'b0010);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    issue(1'b0, `ALU_OR, 16'h00F0, 16'h0F00);
    wait_rsp(lat);
    repeat (3) @(negedge clock);

    issue(1'b1, `ALU_ADD, 16'h1234, 16'h5678);
    repeat (7) @(posedge clock);
    #1 check("mul_mid_op", {29'd0, alu_op}, {29'd0, `ALU_ADD});
    check("mul_mid_valid", {31'd0, rsp_valid}, 32'd0);
    #2 reset = 1'b1;
    #1 check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp", {rsp_result_hi, rsp_result}, 32'd0);
    check("rst_flags_op", {25'd0, rsp_flags, alu_op}, 32'd0);
    check("rst_alu", {alu_a, alu_b}, 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    #1 check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, `ALU_AND, 16'hF0F0, 16'h0FF0);
    wait_rsp(lat);
    check("and_result", {16'd0, rsp_result}, 32'h00F0);
    repeat (3) @(negedge clock);

    rsp_cycles.delete();
    issue(1'b0, `ALU_ADD, 16'd1, 16'd2);
    issue(1'b0, `ALU_ADD, 16'd3, 16'd4);
    repeat (6) @(negedge clock);
    check("b2b_count", rsp_cycles.size(), 32'd2);
    if (rsp_cycles.size() == 2) begin
`ifdef ALU_SEQ_B2B_EN
      check("b2b_spacing", rsp_cycles[1] - rsp_cycles[0], 32'd2);
`else
      check("b2b_spacing", rsp_cycles[1] - rsp_cycles[0], 32'd3);
`endif
    end

    for (int i = 0; i < 10; i++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      issue(m, 3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom));
      wait_rsp(lat);
      check("rand_latency", lat, m ? 32'd16 : 32'd1);
      repeat (2) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    check("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
